// File: rtl/ham_15_11_decoder_pipe.sv
`timescale 1ns/1ps
// Two-stage pipelined Hamming(15,11) single-error-correcting decoder with valid/ready flow control.
// Optional corrected-word counter is compiled in when HAM_DEC_ERR_CNT_EN is defined.
module ham_15_11_decoder_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] c,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] d,
    output logic [3:0]  syn,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        cnt_clr,
    output logic [15:0] err_cnt
);

    // Handshake: a word moves on any rising edge where its valid and the matching ready are both high;
    // a stage advances when it is empty or the stage after it is advancing, so in_ready is combinational.
    logic        v1_q, v1_d;
    logic [14:0] c1_q, c1_d;
    logic [3:0]  syn1_q, syn1_d;
    logic        v2_q, v2_d;
    logic [10:0] d2_q, d2_d;
    logic [3:0]  syn2_q, syn2_d;
    logic        err2_q, err2_d;

    logic        adv1, adv2;
    logic [3:0]  syn_in;
    logic [14:0] flip_mask;
    logic [14:0] cw_fix;

    always_comb begin
        adv2 = !v2_q || out_ready;
        adv1 = !v1_q || adv2;
    end

    assign in_ready = adv1;

    // Syndrome bit k collects every codeword position whose 1-based index has bit k set.
    always_comb begin
        syn_in = '0;
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syn_in[k] = syn_in[k] ^ c[i];
                end
            end
        end
    end

    always_comb begin
        v1_d   = v1_q;
        c1_d   = c1_q;
        syn1_d = syn1_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                c1_d   = c;
                syn1_d = syn_in;
            end
        end
    end

    // A zero syndrome shifts the single 1 out entirely, so clean words pass untouched.
    always_comb begin
        flip_mask = 15'((16'd1 << syn1_q) >> 1);
        cw_fix    = c1_q ^ flip_mask;
    end

    always_comb begin
        v2_d   = v2_q;
        d2_d   = d2_q;
        syn2_d = syn2_q;
        err2_d = err2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                d2_d   = {cw_fix[14:8], cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
                syn2_d = syn1_q;
                err2_d = (syn1_q != 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            c1_q   <= '0;
            syn1_q <= '0;
            v2_q   <= 1'b0;
            d2_q   <= '0;
            syn2_q <= '0;
            err2_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            c1_q   <= c1_d;
            syn1_q <= syn1_d;
            v2_q   <= v2_d;
            d2_q   <= d2_d;
            syn2_q <= syn2_d;
            err2_q <= err2_d;
        end
    end

    assign d         = d2_q;
    assign syn       = syn2_q;
    assign err       = err2_q;
    assign out_valid = v2_q;

`ifdef HAM_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (v2_q && out_ready && err2_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_ham_15_11_decoder_pipe.sv
`timescale 1ns/1ps
// Bench for ham_15_11_decoder_pipe: arithmetic reference model with an expected-word queue,
// a per-cycle compare process, and directed vectors with literal expectations.
module tb_ham_15_11_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic [14:0] c;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] d;
    logic [3:0]  syn;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [15:0] err_cnt;

    int          tests;
    int          fails;
    int          n_out;
    logic        hold_prev;
    logic [15:0] exp_cnt;
    logic [15:0] exp_q[$];

    ham_15_11_decoder_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c        (c),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .syn      (syn),
        .err      (err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_clr  (cnt_clr),
        .err_cnt  (err_cnt)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: syndrome is the XOR of the 1-based positions of all set bits; data are the
    // non-power-of-two positions in ascending order. Result packed as {err, syn, d}.
    function automatic logic [15:0] model(input logic [14:0] cw);
        int          s;
        int          k;
        logic [14:0] w;
        logic [10:0] dd;
        s  = 0;
        k  = 0;
        w  = cw;
        dd = '0;
        for (int i = 0; i < 15; i++) if (cw[i]) s = s ^ (i + 1);
        if (s != 0) w[s - 1] = ~w[s - 1];
        for (int i = 0; i < 15; i++) begin
            if (((i + 1) & i) != 0) begin
                dd[k] = w[i];
                k++;
            end
        end
        return {(s != 0), 4'(s), dd};
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        logic [15:0] front;
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
            if (hold_prev) check("hold_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    front = exp_q[0];
                    check("d", 32'(d), 32'(front[10:0]));
                    check("syn", 32'(syn), 32'(front[14:11]));
                    check("err", 32'(err), 32'(front[15]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
`ifdef HAM_DEC_ERR_CNT_EN
                        if (front[15] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
                    end
                end
            end
`ifdef HAM_DEC_ERR_CNT_EN
            if (cnt_clr) exp_cnt = '0;
`endif
            hold_prev = out_valid && !out_ready;
            if (in_valid && in_ready) exp_q.push_back(model(c));
        end
    end

    // driver tasks: all are entered and left 1 ns after a rising edge
    task automatic send(input logic [14:0] cw);
        logic acc;
        int   tries;
        in_valid = 1'b1;
        c        = cw;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic lat_check(input string name, input logic [14:0] cw,
                             input logic [10:0] ed, input logic [3:0] es, input logic ee);
        logic [15:0] m;
        m = model(cw);
        check({name, "_model"}, 32'(m), 32'({ee, es, ed}));
        drain();
        send(cw);
        @(negedge clk);
        check({name, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_d"}, 32'(d), 32'(ed));
        check({name, "_syn"}, 32'(syn), 32'(es));
        check({name, "_err"}, 32'(err), 32'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] bp_w [3];
        logic        acc;
        int          idx;
        int          start;
        int          t;

        tests     = 0;
        fails     = 0;
        n_out     = 0;
        hold_prev = 1'b0;
        exp_cnt   = '0;
        rst_n     = 1'b1;
        c         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_syn", 32'(syn), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // directed vectors with hand-computed results
        lat_check("clean0", 15'h0000, 11'h000, 4'd0, 1'b0);
        lat_check("clean1", 15'h7FFF, 11'h7FF, 4'd0, 1'b0);
        lat_check("data_err", 15'h0020, 11'h000, 4'd6, 1'b1);
        lat_check("par_err", 15'h7F7F, 11'h7FF, 4'd8, 1'b1);
        lat_check("double_err", 15'h0003, 11'h001, 4'd3, 1'b1);
        lat_check("last_bit", 15'h4000, 11'h000, 4'd15, 1'b1);

        // backpressure: two words fit, the third must wait
        drain();
        bp_w[0]   = 15'h0001;
        bp_w[1]   = 15'h0100;
        bp_w[2]   = 15'h4000;
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        c         = bp_w[0];
        repeat (4) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) c = bp_w[idx];
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts", 32'(idx), 32'd2);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start     = n_out;
        out_ready = 1'b1;
        t         = 0;
        while (idx < 3 && t < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        t        = 0;
        while ((n_out - start) < 3 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_emitted", 32'(n_out - start), 32'd3);

        // mixed traffic with random handshakes
        in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                c        = 15'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drain();

        // reset with the pipeline full
        out_ready = 1'b0;
        send(15'h1234);
        send(15'h0ABC);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        hold_prev = 1'b0;
        exp_cnt   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lat_check("post_midrst", 15'h7F7F, 11'h7FF, 4'd8, 1'b1);

`ifdef HAM_DEC_ERR_CNT_EN
        // counter saturation and clear
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c         = 15'h0020;
        idx       = 0;
        t         = 0;
        while (idx < 65537 && t < 70000) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        check("sat_accepts", 32'(idx), 32'd65537);
        drain();
        check("cnt_saturated", 32'(err_cnt), 32'h0000FFFF);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        check("cnt_cleared", 32'(err_cnt), 32'd0);
`endif

        drain();
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
